// File: rtl/row_length_encoder_pkg.sv
// Shared types and default sizing for the row-length encoder and its row counter.
package row_length_encoder_pkg;

  localparam int DEF_ROW_W    = 5;
  localparam int DEF_LEN_W    = 5;
  localparam int DEF_NUM_ROWS = 32;

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_EMIT  = 2'd1,
    S_FILL  = 2'd2
  } rle_state_e;

endpackage

// File: rtl/row_length_encoder.sv
// Turns a row-ordered nonzero-element stream into one length word per matrix row.
// Optional ROW_ORDER_CHECK_EN drops out-of-order/out-of-range elements and flags order_err.
module row_length_encoder
  import row_length_encoder_pkg::*;
#(
  parameter int ROW_W    = DEF_ROW_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [LEN_W-1:0] out_len,
  output logic             out_last,
  output logic             out_sat
`ifdef ROW_ORDER_CHECK_EN
  ,
  output logic             order_err
`endif
);

  localparam logic [LEN_W-1:0] CNT_MAX  = '1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  rle_state_e       state_q, state_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             final_q, final_d;
  logic             pend_vld_q, pend_vld_d;
  logic [ROW_W-1:0] pend_row_q, pend_row_d;
  logic             pend_last_q, pend_last_d;
  logic             err_q, err_d;
  logic             bad_elem;
  logic [ROW_W-1:0] next_row;

`ifdef ROW_ORDER_CHECK_EN
  assign bad_elem  = (in_row < cur_row_q) ||
                     ({1'b0, in_row} >= (ROW_W+1)'(NUM_ROWS));
  assign order_err = err_q;
`else
  assign bad_elem  = 1'b0;
`endif

  assign next_row = cur_row_q + ROW_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_COUNT;
      cur_row_q   <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      final_q     <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_row_q  <= '0;
      pend_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      final_q     <= final_d;
      pend_vld_q  <= pend_vld_d;
      pend_row_q  <= pend_row_d;
      pend_last_q <= pend_last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    final_d     = final_q;
    pend_vld_d  = pend_vld_q;
    pend_row_d  = pend_row_q;
    pend_last_d = pend_last_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_row     = '0;
    out_len     = '0;
    out_last    = 1'b0;
    out_sat     = 1'b0;

    case (state_q)
      S_COUNT: begin
        in_ready = !reset;
        if (in_valid) begin
          if (bad_elem) begin
            err_d = 1'b1;
          end else if (in_row == cur_row_q) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + LEN_W'(1);
            if (in_last) begin
              final_d = 1'b1;
              state_d = S_EMIT;
            end
          end else begin
            // Element opens a later row: park it until that row becomes current.
            pend_vld_d  = 1'b1;
            pend_row_d  = in_row;
            pend_last_d = in_last;
            state_d     = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        out_valid = 1'b1;
        out_row   = cur_row_q;
        out_len   = cnt_q;
        out_sat   = sat_q;
        out_last  = (cur_row_q == LAST_ROW);
        if (out_ready) begin
          cnt_d = '0;
          sat_d = 1'b0;
          if (cur_row_q == LAST_ROW) begin
            cur_row_d  = '0;
            final_d    = 1'b0;
            pend_vld_d = 1'b0;
            state_d    = S_COUNT;
          end else begin
            cur_row_d = next_row;
            if (pend_vld_q && pend_row_q == next_row) begin
              cnt_d      = LEN_W'(1);
              pend_vld_d = 1'b0;
              final_d    = pend_last_q;
              // A parked last element already closes its row, so emit it directly.
              state_d    = pend_last_q ? S_EMIT : S_COUNT;
            end else if (pend_vld_q) begin
              state_d = S_EMIT;
            end else if (final_q) begin
              state_d = S_FILL;
            end else begin
              state_d = S_COUNT;
            end
          end
        end
      end

      S_FILL: begin
        out_valid = 1'b1;
        out_row   = cur_row_q;
        out_last  = (cur_row_q == LAST_ROW);
        if (out_ready) begin
          if (cur_row_q == LAST_ROW) begin
            cur_row_d = '0;
            cnt_d     = '0;
            final_d   = 1'b0;
            state_d   = S_COUNT;
          end else begin
            cur_row_d = next_row;
          end
        end
      end

      default: state_d = S_COUNT;
    endcase
  end

endmodule

// File: tb/tb_row_length_encoder.sv
// Randomized bench for row_length_encoder against a per-row counting model.
module tb_row_length_encoder;

  localparam int ROW_W = 2;
  localparam int LEN_W = 5;
  localparam int NR    = 4;
  localparam int MAXC  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_last;
  logic [ROW_W-1:0] in_row;
  logic             out_valid, out_ready, out_last, out_sat;
  logic [ROW_W-1:0] out_row;
  logic [LEN_W-1:0] out_len;
`ifdef ROW_ORDER_CHECK_EN
  logic             order_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  row_length_encoder #(.ROW_W(ROW_W), .LEN_W(LEN_W), .NUM_ROWS(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_len  (out_len),
    .out_last (out_last),
    .out_sat  (out_sat)
`ifdef ROW_ORDER_CHECK_EN
    ,
    .order_err(order_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feeds one matrix and checks every emitted word against counts computed from the element list.
  task automatic run_matrix(input int rows[$], input int pct, input int stall);
    int exp_len[NR];
    bit exp_sat[NR];
    int idx, ew, n, stall_left;
    bit stalled;
    logic [31:0] s_row, s_len, s_sat, s_last;
`ifdef ROW_ORDER_CHECK_EN
    int hi = 0;
`endif
    n = rows.size();
    for (int r = 0; r < NR; r++) begin exp_len[r] = 0; exp_sat[r] = 0; end
    for (int i = 0; i < n; i++) begin
`ifdef ROW_ORDER_CHECK_EN
      if (rows[i] < hi) continue;
      hi = rows[i];
`endif
      if (exp_len[rows[i]] == MAXC) exp_sat[rows[i]] = 1'b1;
      else                          exp_len[rows[i]]++;
    end
    idx = 0; ew = 0; stalled = 0; stall_left = stall;
    s_row = 0; s_len = 0; s_sat = 0; s_last = 0;
    for (int cyc = 0; cyc < 3000 && ew < NR; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_row", out_row, s_row);
        check("stall_len", out_len, s_len);
        check("stall_sat", out_sat, s_sat);
        check("stall_last", out_last, s_last);
        stalled = 0;
      end
      if (out_valid) check("in_ready_in_emit", in_ready, 0);
      if (idx < n) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_row   = ROW_W'(rows[idx]);
        in_last  = (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) < pct);
      end
      if (out_valid && out_ready) begin
        check("word_row", out_row, ew);
        check("word_len", out_len, exp_len[ew]);
        check("word_sat", out_sat, exp_sat[ew]);
        check("word_last", out_last, (ew == NR - 1));
        ew++;
      end else if (out_valid) begin
        stalled = 1;
        s_row = out_row; s_len = out_len; s_sat = out_sat; s_last = out_last;
      end
      if (in_valid && in_ready) idx++;
    end
    check("words_done", ew, NR);
    check("elems_done", idx, n);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_len"}, out_len, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_sat"}, out_sat, 0);
  endtask

  initial begin
    int q[$];
    reset = 1'b1; in_valid = 1'b0; in_row = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    run_matrix('{0, 0, 1, 1, 1, 3}, 100, 0);
    run_matrix('{0}, 100, 0);
    q = {};
    repeat (33) q.push_back(0);
    q.push_back(1);
    run_matrix(q, 100, 0);
    run_matrix('{0, 0, 1, 1, 1, 3}, 100, 5);
    run_matrix('{3}, 60, 5);

    // Abort a matrix partway through row 1.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_row = 2'd1; in_last = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrst_rel_in_ready", in_ready, 1);
    run_matrix('{0, 2}, 100, 0);

    for (int m = 0; m < 20; m++) begin
      int len;
      q = {};
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, NR - 1));
      q.sort();
      run_matrix(q, $urandom_range(30, 100), $urandom_range(0, 3));
    end

`ifdef ROW_ORDER_CHECK_EN
    run_matrix('{2, 1, 3}, 100, 0);
    check("order_err", order_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
